// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// J/JAL constants exist only when MC_JUMP_EN is defined.
package mips_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0c;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
`endif

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC     = 4'd2,
        ST_ALU_WB   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_TRAP     = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_ANDI  = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] RD_RT      = 2'b00;
    localparam logic [1:0] RD_RD      = 2'b01;
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
`ifdef MC_JUMP_EN
    localparam logic [1:0] PC_JUMP    = 2'b10;
    localparam logic [1:0] RD_RA      = 2'b10;
    localparam logic [1:0] M2R_PC     = 2'b10;
`endif

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-line decode from FSM state and latched opcode.
// JUMP-state outputs are produced only when MC_JUMP_EN is defined.
module mc_output_decode
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int OP_W    = 6
) (
    input  logic               i_reset,
    input  state_t             i_state,
    input  logic [OP_W-1:0]    i_op_q,
    input  logic               i_mem_ready,
    output logic               o_ir_write,
    output logic               o_pc_write,
    output logic               o_iord,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_reg_write,
    output logic               o_alu_src_a,
    output logic               o_branch_eq,
    output logic               o_branch_ne,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_pc_source,
    output logic [1:0]         o_reg_dst,
    output logic [1:0]         o_mem_to_reg,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_instr_done,
    output logic               o_illegal_op
);

    localparam logic [OP_W-1:0] L_RTYPE = OP_W'(OPC_RTYPE);
    localparam logic [OP_W-1:0] L_ADDI  = OP_W'(OPC_ADDI);
    localparam logic [OP_W-1:0] L_ANDI  = OP_W'(OPC_ANDI);
    localparam logic [OP_W-1:0] L_ORI   = OP_W'(OPC_ORI);
    localparam logic [OP_W-1:0] L_LUI   = OP_W'(OPC_LUI);
    localparam logic [OP_W-1:0] L_BEQ   = OP_W'(OPC_BEQ);
    localparam logic [OP_W-1:0] L_BNE   = OP_W'(OPC_BNE);
`ifdef MC_JUMP_EN
    localparam logic [OP_W-1:0] L_JAL   = OP_W'(OPC_JAL);
`endif

    logic [2:0] w_alu_code;

    always_comb begin
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_iord       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_branch_eq  = 1'b0;
        o_branch_ne  = 1'b0;
        o_alu_src_b  = SRCB_REG;
        o_pc_source  = PC_ALU;
        o_reg_dst    = RD_RT;
        o_mem_to_reg = M2R_ALUOUT;
        w_alu_code   = ALU_ADD;
        o_instr_done = 1'b0;
        o_illegal_op = 1'b0;
        // Reset overrides everything so an in-flight write is cancelled in the reset cycle
        if (!i_reset) begin
            case (i_state)
                ST_FETCH: begin
                    o_mem_read  = 1'b1;
                    o_alu_src_b = SRCB_FOUR;
                    o_ir_write  = i_mem_ready;
                    o_pc_write  = i_mem_ready;
                end
                ST_DECODE: o_alu_src_b = SRCB_IMM_SH;
                ST_EXEC: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = (i_op_q == L_RTYPE) ? SRCB_REG : SRCB_IMM;
                    case (i_op_q)
                        L_RTYPE: w_alu_code = ALU_RTYPE;
                        L_ADDI:  w_alu_code = ALU_ADDI;
                        L_ORI:   w_alu_code = ALU_ORI;
                        L_ANDI:  w_alu_code = ALU_ANDI;
                        L_LUI:   w_alu_code = ALU_LUI;
                        default: w_alu_code = ALU_ADD;
                    endcase
                end
                ST_ALU_WB: begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = (i_op_q == L_RTYPE) ? RD_RD : RD_RT;
                    o_instr_done = 1'b1;
                end
                ST_MEM_ADDR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    o_iord     = 1'b1;
                    o_mem_read = 1'b1;
                end
                ST_MEM_WB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = M2R_MDR;
                    o_instr_done = 1'b1;
                end
                ST_MEM_WR: begin
                    o_iord       = 1'b1;
                    o_mem_write  = 1'b1;
                    o_instr_done = i_mem_ready;
                end
                ST_BRANCH: begin
                    o_alu_src_a  = 1'b1;
                    w_alu_code   = ALU_SUB;
                    o_pc_source  = PC_ALUOUT;
                    o_branch_eq  = (i_op_q == L_BEQ);
                    o_branch_ne  = (i_op_q == L_BNE);
                    o_instr_done = 1'b1;
                end
`ifdef MC_JUMP_EN
                ST_JUMP: begin
                    o_pc_source  = PC_JUMP;
                    o_pc_write   = 1'b1;
                    o_instr_done = 1'b1;
                    if (i_op_q == L_JAL) begin
                        o_reg_write  = 1'b1;
                        o_reg_dst    = RD_RA;
                        o_mem_to_reg = M2R_PC;
                    end
                end
`endif
                ST_TRAP: o_illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_alu_op = ALUOP_W'(w_alu_code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, opcode latch and next-state logic.
// Define MC_JUMP_EN to decode J/JAL; otherwise they trap as illegal opcodes.
//
// state     | meaning
// FETCH     | read instruction, PC+4; waits on MemReady
// DECODE    | latch opcode, compute branch target
// EXEC      | ALU op for R-type / immediate instructions
// ALU_WB    | write ALU result to register file
// MEM_ADDR  | compute load/store address
// MEM_RD    | data read; waits on MemReady
// MEM_WB    | write loaded data to register file
// MEM_WR    | data write; waits on MemReady
// BRANCH    | compare and conditionally redirect PC
// JUMP      | jump / jump-and-link
// TRAP      | illegal opcode, held until reset
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    OP,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               BranchEQ,
    output logic               BranchNE,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               InstrDone,
    output logic               IllegalOp
);

    localparam logic [OP_W-1:0] L_RTYPE = OP_W'(OPC_RTYPE);
    localparam logic [OP_W-1:0] L_ADDI  = OP_W'(OPC_ADDI);
    localparam logic [OP_W-1:0] L_ANDI  = OP_W'(OPC_ANDI);
    localparam logic [OP_W-1:0] L_ORI   = OP_W'(OPC_ORI);
    localparam logic [OP_W-1:0] L_LUI   = OP_W'(OPC_LUI);
    localparam logic [OP_W-1:0] L_LW    = OP_W'(OPC_LW);
    localparam logic [OP_W-1:0] L_SW    = OP_W'(OPC_SW);
    localparam logic [OP_W-1:0] L_BEQ   = OP_W'(OPC_BEQ);
    localparam logic [OP_W-1:0] L_BNE   = OP_W'(OPC_BNE);
`ifdef MC_JUMP_EN
    localparam logic [OP_W-1:0] L_J     = OP_W'(OPC_J);
    localparam logic [OP_W-1:0] L_JAL   = OP_W'(OPC_JAL);
`endif

    state_t          r_state;
    logic [OP_W-1:0] r_op_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_op_q  <= '0;
        end else begin
            case (r_state)
                ST_FETCH:  if (MemReady) r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_op_q <= OP;
                    // Decode straight from OP: r_op_q is not valid until the next state
                    case (OP)
                        L_RTYPE, L_ADDI, L_ORI, L_ANDI, L_LUI: r_state <= ST_EXEC;
                        L_LW, L_SW:                            r_state <= ST_MEM_ADDR;
                        L_BEQ, L_BNE:                          r_state <= ST_BRANCH;
`ifdef MC_JUMP_EN
                        L_J, L_JAL:                            r_state <= ST_JUMP;
`endif
                        default:                               r_state <= ST_TRAP;
                    endcase
                end
                ST_EXEC:     r_state <= ST_ALU_WB;
                ST_MEM_ADDR: r_state <= (r_op_q == L_SW) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD:   if (MemReady) r_state <= ST_MEM_WB;
                ST_MEM_WR:   if (MemReady) r_state <= ST_FETCH;
                ST_TRAP:     r_state <= ST_TRAP;
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    mc_output_decode #(
        .ALUOP_W (ALUOP_W),
        .OP_W    (OP_W)
    ) u_output_decode (
        .i_reset      (reset),
        .i_state      (r_state),
        .i_op_q       (r_op_q),
        .i_mem_ready  (MemReady),
        .o_ir_write   (IRWrite),
        .o_pc_write   (PCWrite),
        .o_iord       (IorD),
        .o_mem_read   (MemRead),
        .o_mem_write  (MemWrite),
        .o_reg_write  (RegWrite),
        .o_alu_src_a  (ALUSrcA),
        .o_branch_eq  (BranchEQ),
        .o_branch_ne  (BranchNE),
        .o_alu_src_b  (ALUSrcB),
        .o_pc_source  (PCSource),
        .o_reg_dst    (RegDst),
        .o_mem_to_reg (MemtoReg),
        .o_alu_op     (ALUOp),
        .o_instr_done (InstrDone),
        .o_illegal_op (IllegalOp)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected control sequences built from
// the instruction-level behaviour, compared cycle by cycle. Honours MC_JUMP_EN.
module tb_multicycle_control;

    typedef struct packed {
        logic       ir, pcw, iord, mrd, mwr, rw, srca, beq, bne;
        logic [1:0] srcb, pcsrc, regdst, m2r;
        logic [2:0] aluop;
        logic       done, ill;
    } ctl_t;

`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OP = '0;
    logic       MemReady = 1'b0;
    logic       IRWrite, PCWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, BranchEQ, BranchNE;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;
    logic [2:0] ALUOp;
    logic       InstrDone, IllegalOp;
    ctl_t       obs;

    int n_pass = 0;
    int n_total = 0;

    ctl_t       q_exp[$];
    logic       q_mr[$];
    logic [5:0] q_op[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .BranchEQ(BranchEQ), .BranchNE(BranchNE), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUOp(ALUOp), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
    );

    assign obs = {IRWrite, PCWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, BranchEQ,
                  BranchNE, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp, InstrDone, IllegalOp};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic step(input logic rst, input logic mr, input logic [5:0] op);
        @(negedge clk);
        reset    = rst;
        MemReady = mr;
        OP       = op;
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic void push(input ctl_t c, input logic mr, input logic [5:0] op);
        q_exp.push_back(c);
        q_mr.push_back(mr);
        q_op.push_back(op);
    endfunction

    function automatic bit is_alu(input logic [5:0] opc);
        return opc == 6'h00 || opc == 6'h08 || opc == 6'h0c || opc == 6'h0d || opc == 6'h0f;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] opc);
        case (opc)
            6'h00:   return 3'b111;
            6'h08:   return 3'b100;
            6'h0d:   return 3'b101;
            6'h0c:   return 3'b110;
            6'h0f:   return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t fetch_vec(input logic rdy);
        ctl_t c = '0;
        c.mrd  = 1'b1;
        c.srcb = 2'b01;
        c.ir   = rdy;
        c.pcw  = rdy;
        return c;
    endfunction

    // Expected per-cycle outputs for one instruction; returns 1 if it traps.
    function automatic bit build(input logic [5:0] opc, input int fw, input int mw);
        ctl_t c;
        bit trap = 1'b0;
        q_exp.delete(); q_mr.delete(); q_op.delete();
        for (int k = 0; k < fw; k++) push(fetch_vec(1'b0), 1'b0, rnd_op());
        push(fetch_vec(1'b1), 1'b1, rnd_op());
        c = '0; c.srcb = 2'b11;
        push(c, rnd_bit(), opc);
        if (is_alu(opc)) begin
            c = '0; c.srca = 1'b1; c.srcb = (opc == 6'h00) ? 2'b00 : 2'b10; c.aluop = alu_of(opc);
            push(c, rnd_bit(), rnd_op());
            c = '0; c.rw = 1'b1; c.regdst = (opc == 6'h00) ? 2'b01 : 2'b00; c.done = 1'b1;
            push(c, rnd_bit(), rnd_op());
        end else if (opc == 6'h23 || opc == 6'h2b) begin
            c = '0; c.srca = 1'b1; c.srcb = 2'b10;
            push(c, rnd_bit(), rnd_op());
            c = '0; c.iord = 1'b1;
            if (opc == 6'h23) c.mrd = 1'b1; else c.mwr = 1'b1;
            for (int k = 0; k < mw; k++) push(c, 1'b0, rnd_op());
            if (opc == 6'h2b) c.done = 1'b1;
            push(c, 1'b1, rnd_op());
            if (opc == 6'h23) begin
                c = '0; c.rw = 1'b1; c.m2r = 2'b01; c.done = 1'b1;
                push(c, rnd_bit(), rnd_op());
            end
        end else if (opc == 6'h04 || opc == 6'h05) begin
            c = '0; c.srca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.done = 1'b1;
            c.beq = (opc == 6'h04); c.bne = (opc == 6'h05);
            push(c, rnd_bit(), rnd_op());
        end else if (JUMP_EN && (opc == 6'h02 || opc == 6'h03)) begin
            c = '0; c.pcsrc = 2'b10; c.pcw = 1'b1; c.done = 1'b1;
            if (opc == 6'h03) begin c.rw = 1'b1; c.regdst = 2'b10; c.m2r = 2'b10; end
            push(c, rnd_bit(), rnd_op());
        end else begin
            c = '0; c.ill = 1'b1;
            for (int k = 0; k < 10; k++) push(c, rnd_bit(), rnd_op());
            trap = 1'b1;
        end
        return trap;
    endfunction

    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, input string name);
        bit trap;
        trap = build(opc, fw, mw);
        for (int i = 0; i < q_exp.size(); i++) begin
            step(1'b0, q_mr[i], q_op[i]);
            n_total++;
            if (obs !== q_exp[i])
                $display("FAIL %s op=%h cyc%0d: got %h want %h", name, opc, i, obs, q_exp[i]);
            else
                n_pass++;
        end
        if (trap) begin
            step(1'b1, rnd_bit(), rnd_op());
            n_total++;
            if (obs !== ctl_t'(0))
                $display("FAIL %s trap-reset op=%h: got %h want %h", name, opc, obs, ctl_t'(0));
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rnd_bit(), rnd_op());
            n_total++;
            if (obs !== ctl_t'(0))
                $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, ctl_t'(0));
            else
                n_pass++;
        end
    endtask

    task automatic test_alu();
        run_instr(6'h00, 0, 0, "alu_rtype_first");
        run_instr(6'h08, 2, 0, "alu_addi_wait");
        run_instr(6'h0d, 0, 0, "alu_ori");
        run_instr(6'h0c, 1, 0, "alu_andi");
        run_instr(6'h0f, 0, 0, "alu_lui");
    endtask

    task automatic test_load_store();
        run_instr(6'h23, 0, 2, "lw_wait2");
        run_instr(6'h23, 0, 0, "lw");
        run_instr(6'h2b, 1, 0, "sw");
        run_instr(6'h2b, 0, 3, "sw_wait3");
    endtask

    task automatic test_branch();
        run_instr(6'h05, 0, 0, "bne");
        run_instr(6'h04, 0, 0, "beq");
    endtask

    task automatic test_jump();
        run_instr(6'h03, 0, 0, "jal");
        run_instr(6'h02, 0, 0, "j");
    endtask

    task automatic test_illegal();
        run_instr(6'h3f, 0, 0, "illegal");
        run_instr(6'h00, 0, 0, "after_trap");
    endtask

    task automatic test_reset_mid_write();
        ctl_t       e[6];
        logic       rs[6];
        logic       mr[6];
        logic [5:0] op[6];
        e[0] = fetch_vec(1'b1); rs[0] = 1'b0; mr[0] = 1'b1; op[0] = rnd_op();
        e[1] = '0; e[1].srcb = 2'b11; rs[1] = 1'b0; mr[1] = 1'b0; op[1] = 6'h2b;
        e[2] = '0; e[2].srca = 1'b1; e[2].srcb = 2'b10; rs[2] = 1'b0; mr[2] = 1'b1; op[2] = rnd_op();
        e[3] = '0; e[3].iord = 1'b1; e[3].mwr = 1'b1; rs[3] = 1'b0; mr[3] = 1'b0; op[3] = rnd_op();
        e[4] = '0; rs[4] = 1'b1; mr[4] = 1'b1; op[4] = rnd_op();
        e[5] = fetch_vec(1'b0); rs[5] = 1'b0; mr[5] = 1'b0; op[5] = rnd_op();
        for (int i = 0; i < 6; i++) begin
            step(rs[i], mr[i], op[i]);
            n_total++;
            if (obs !== e[i])
                $display("FAIL reset_mid_write cyc%0d: got %h want %h", i, obs, e[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        logic [5:0] opc;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 12))
                0: opc = 6'h00;  1: opc = 6'h08;  2: opc = 6'h0c;  3: opc = 6'h0d;
                4: opc = 6'h0f;  5: opc = 6'h23;  6: opc = 6'h2b;  7: opc = 6'h04;
                8: opc = 6'h05;  9: opc = 6'h02;  10: opc = 6'h03;
                default: opc = rnd_op();
            endcase
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
